// File: rtl/spill_fifo.sv
// -----------------------------------------------------------------------------
// spill_fifo
//   Elastic valid/ready buffer of Depth entries that fully decouples the
//   upstream and downstream channels: ready_o, valid_o and usage_o depend only
//   on registered state (plus flush_i), and data_o is a mux of registers.
//   At Depth = 2 it behaves exactly like a classic spill register.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (control state only)
//   flush_i  : synchronous discard of every stored entry
//   valid_i  : upstream valid          ready_o : upstream ready
//   data_i   : upstream payload
//   valid_o  : downstream valid        ready_i : downstream ready
//   data_o   : downstream payload (don't-care while valid_o = 0)
//   usage_o  : number of stored entries
//   hwm_o    : peak usage since reset or flush
//
// Configuration
//   SPILL_FIFO_HWM_EN : when defined, hwm_o is a high-water-mark register;
//                       otherwise hwm_o is tied to zero.
// -----------------------------------------------------------------------------
module spill_fifo #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned Depth      = 2,
    parameter int unsigned UsageWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DataWidth-1:0]  data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DataWidth-1:0]  data_o,
    output logic [UsageWidth-1:0] usage_o,
    output logic [UsageWidth-1:0] hwm_o
);

    // A single-entry buffer still needs a one-bit pointer to keep the
    // declarations legal; it simply never leaves zero.
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [UsageWidth-1:0] count_q, count_d;

    logic full, empty, push, pop;

    // Pointers wrap at Depth-1, so any depth works, not only powers of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(Depth - 1)) begin
            return '0;
        end
        return p + PtrWidth'(1);
    endfunction

    assign full  = (count_q == UsageWidth'(Depth));
    assign empty = (count_q == '0);

    // Ready never looks at the pop side: a full buffer stays not-ready even in
    // a cycle where an entry leaves, which is what breaks the ready path.
    assign ready_o = !full && !flush_i;
    assign valid_o = !empty && !flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign usage_o = count_q;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + UsageWidth'(1);
                2'b01:   count_d = count_q - UsageWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; stale contents are never visible
    // because valid_o is gated by the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef SPILL_FIFO_HWM_EN
    logic [UsageWidth-1:0] hwm_q, hwm_d;

    // Tracks the next count so the peak is visible together with usage_o.
    always_comb begin
        hwm_d = hwm_q;
        if (flush_i) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

endmodule

// File: tb/tb_spill_fifo.sv
// -----------------------------------------------------------------------------
// tb_spill_fifo
//   Bench for spill_fifo using three instances: Depth 4, Depth 2 and Depth 3,
//   all 8 bits wide. Stimulus pushes expected beats into per-instance queues;
//   a monitor on the falling edge pops and compares every beat transferred.
// -----------------------------------------------------------------------------
module tb_spill_fifo;

`ifdef SPILL_FIFO_HWM_EN
    localparam int HwmFull4 = 4;
`else
    localparam int HwmFull4 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       fl  [3];
    logic       vi  [3];
    logic       ro  [3];
    logic [7:0] di  [3];
    logic       vo  [3];
    logic       ri  [3];
    logic [7:0] dout[3];

    logic [2:0] us4, hw4;
    logic [1:0] us2, hw2;
    logic [1:0] us3, hw3;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spill_fifo #(.DataWidth(8), .Depth(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]),
        .valid_i(vi[0]), .ready_o(ro[0]), .data_i(di[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .data_o(dout[0]),
        .usage_o(us4), .hwm_o(hw4)
    );

    spill_fifo #(.DataWidth(8), .Depth(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]),
        .valid_i(vi[1]), .ready_o(ro[1]), .data_i(di[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .data_o(dout[1]),
        .usage_o(us2), .hwm_o(hw2)
    );

    spill_fifo #(.DataWidth(8), .Depth(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]),
        .valid_i(vi[2]), .ready_o(ro[2]), .data_i(di[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .data_o(dout[2]),
        .usage_o(us3), .hwm_o(hw3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push_exp(input int k, input logic [7:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    task automatic pop_cmp(input int k, input logic [7:0] act);
        logic [7:0] e;
        int sz;
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        n_chk++;
        if (sz == 0) begin
            $display("FAIL beat_unexpected[%0d]: got %0h expected none", k, act);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if (act == e) n_pass++;
            else $display("FAIL beat_data[%0d]: got %0h expected %0h", k, act, e);
        end
    endtask

    // Monitor: a beat is transferred at the next rising edge when valid and
    // ready are both high mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && vo[k] && ri[k]) pop_cmp(k, dout[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int k, input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        vi[k] = 1'b1;
        di[k] = v;
        push_exp(k, v);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ro[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_accept", int'(ok), 1);
        step();
        vi[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int lim, input bit stall);
        bit done;
        done = 1'b0;
        for (int c = 0; c < lim; c++) begin
            ri[k] = stall ? ((c % 3) != 1) : 1'b1;
            @(negedge clk);
            if (!vo[k]) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("drain_done", int'(done), 1);
        step();
        ri[k] = 1'b0;
    endtask

    initial begin
        int bad_use, bad_gap, n;
        for (int k = 0; k < 3; k++) begin
            fl[k] = 1'b0; vi[k] = 1'b0; ri[k] = 1'b0; di[k] = 8'h00;
        end

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(ro[0]), 1);
        chk("rst_valid", int'(vo[0]), 0);
        chk("rst_usage", int'(us4), 0);
        chk("rst_hwm",   int'(hw4), 0);
        step();

        // Fill Depth 4 with downstream stalled, then drain
        for (int i = 0; i < 4; i++) begin
            vi[0] = 1'b1;
            di[0] = 8'(8'h11 * (i + 1));
            push_exp(0, di[0]);
            @(negedge clk);
            chk("fill_ready", int'(ro[0]), 1);
            step();
            vi[0] = 1'b0;
            @(negedge clk);
            chk("fill_usage", int'(us4), i + 1);
            step();
        end
        @(negedge clk);
        chk("full_ready", int'(ro[0]), 0);
        chk("full_valid", int'(vo[0]), 1);
        chk("full_hwm",   int'(hw4), HwmFull4);
        step();
        ri[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", int'(vo[0]), 1);
            step();
        end
        @(negedge clk);
        chk("empty_valid", int'(vo[0]), 0);
        chk("empty_usage", int'(us4), 0);
        chk("drained_hwm", int'(hw4), HwmFull4);
        step();

        // Streaming, 100 beats
        bad_use = 0;
        bad_gap = 0;
        ri[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            vi[0] = 1'b1;
            di[0] = 8'(k);
            push_exp(0, di[0]);
            @(negedge clk);
            if (!ro[0]) bad_gap++;
            if (k > 0 && us4 != 3'd1) bad_use++;
            if (k > 0 && !vo[0]) bad_gap++;
            step();
        end
        vi[0] = 1'b0;
        chk("stream_usage_bad", bad_use, 0);
        chk("stream_gap_bad", bad_gap, 0);
        drain(0, 10, 1'b0);

        // Depth 2: full buffer with a pop in the same cycle
        push_beat(1, 8'hA0);
        push_beat(1, 8'hB0);
        @(negedge clk);
        chk("d2_full_ready", int'(ro[1]), 0);
        chk("d2_full_usage", int'(us2), 2);
        step();
        ri[1] = 1'b1;
        vi[1] = 1'b1;
        di[1] = 8'hC0;
        push_exp(1, 8'hC0);
        @(negedge clk);
        chk("d2_pop_ready", int'(ro[1]), 0);
        step();
        @(negedge clk);
        chk("d2_after_ready", int'(ro[1]), 1);
        chk("d2_after_usage", int'(us2), 1);
        step();
        vi[1] = 1'b0;
        drain(1, 10, 1'b0);

        // Flush with 3 stored entries and an upstream beat waiting
        push_beat(0, 8'hA1);
        push_beat(0, 8'hA2);
        push_beat(0, 8'hA3);
        vi[0] = 1'b1;
        di[0] = 8'h5A;
        fl[0] = 1'b1;
        q0.delete();
        push_exp(0, 8'h5A);
        @(negedge clk);
        chk("flush_ready", int'(ro[0]), 0);
        chk("flush_valid", int'(vo[0]), 0);
        step();
        fl[0] = 1'b0;
        @(negedge clk);
        chk("post_flush_usage", int'(us4), 0);
        chk("post_flush_hwm",   int'(hw4), 0);
        chk("post_flush_ready", int'(ro[0]), 1);
        step();
        vi[0] = 1'b0;
        drain(0, 10, 1'b0);

        // Depth 3: repeated fill/drain with stalls, forcing pointer wrap
        for (int r = 0; r < 10; r++) begin
            n = (r % 2) ? 2 : 3;
            for (int j = 0; j < n; j++) push_beat(2, 8'(r * 16 + j));
            if (n == 3) begin
                @(negedge clk);
                chk("d3_full_ready", int'(ro[2]), 0);
                step();
            end
            drain(2, 30, 1'b1);
        end

        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
